// File: rtl/nios2pio_memtest_pkg.sv
// Shared types, constants and the fill/check pattern for the
// on-chip RAM self-test master.
package nios2pio_memtest_pkg;

    localparam int DEF_DEPTH = 2048;
    localparam int DEF_AW    = 11;
    localparam int DEF_DW    = 32;

    localparam logic [1:0] MODE_FILL       = 2'd0;
    localparam logic [1:0] MODE_CHECK      = 2'd1;
    localparam logic [1:0] MODE_FILL_CHECK = 2'd2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Address in both polarities keeps stuck and coupled bits visible.
    function automatic logic [31:0] pattern(input logic [31:0] seed,
                                            input logic [10:0] a);
        return seed ^ {a, ~a, a[9:0]};
    endfunction

endpackage

// File: rtl/nios2pio_memtest_rdpipe.sv
// Read-latency tracker: shifts {valid, addr, expected} so each entry
// reaches the output in the cycle its read data is valid.
module nios2pio_memtest_rdpipe
    import nios2pio_memtest_pkg::*;
#(
    parameter int LAT = 1,
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_exp,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_exp,
    output logic          pending
);

    logic [LAT-1:0] v;
    logic [AW-1:0]  a [LAT];
    logic [DW-1:0]  e [LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int i = 0; i < LAT; i++) begin
                a[i] <= '0;
                e[i] <= '0;
            end
        end else begin
            v[0] <= push;
            a[0] <= push_addr;
            e[0] <= push_exp;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
                e[i] <= e[i-1];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_addr  = a[LAT-1];
    assign out_exp   = e[LAT-1];

    // Entries that will still reach the output after this cycle.
    generate
        if (LAT > 1) begin : g_deep
            assign pending = |v[LAT-2:0];
        end else begin : g_flat
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/nios2pio_memtest_master.sv
// Avalon-MM self-test master: fills on-chip RAM with a seeded pattern
// and/or reads it back, counting mismatches and logging the first.
module nios2pio_memtest_master
    import nios2pio_memtest_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
    output logic [AW-1:0] avm_address,
    output logic          avm_chipselect,
    output logic          avm_write,
    output logic [3:0]    avm_byteenable,
    output logic [DW-1:0] avm_writedata,
    output logic          avm_clken,
    input  logic [DW-1:0] avm_readdata
);

    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] addr;
    logic [1:0]    mode_q;
    logic [DW-1:0] seed_q;
    logic          aborted;
    logic          pass_q;
    logic [DW-1:0] pat;
    logic          chk_valid;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] chk_exp;
    logic          pending;
    logic          mismatch;

    assign pat      = pattern(seed_q, addr);
    assign mismatch = chk_valid && (avm_readdata != chk_exp);

    nios2pio_memtest_rdpipe #(
        .LAT (READ_LATENCY),
        .AW  (AW),
        .DW  (DW)
    ) u_rdpipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (state == ST_READ),
        .push_addr (addr),
        .push_exp  (pat),
        .out_valid (chk_valid),
        .out_addr  (chk_addr),
        .out_exp   (chk_exp),
        .pending   (pending)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            addr           <= '0;
            mode_q         <= MODE_FILL;
            seed_q         <= '0;
            aborted        <= 1'b0;
            pass_q         <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            if (abort)
                aborted <= 1'b1;
            if (mismatch) begin
                if (err_count != CNT_MAX)
                    err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_err_addr <= chk_addr;
                    first_err_data <= avm_readdata;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        mode_q         <= mode;
                        addr           <= '0;
                        aborted        <= 1'b0;
                        pass_q         <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        state <= (mode == MODE_CHECK) ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_DONE;
                    end else if (addr == LAST) begin
                        addr  <= '0;
                        state <= (mode_q == MODE_FILL) ? ST_DONE : ST_READ;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                ST_READ: begin
                    if (abort || addr == LAST)
                        state <= ST_DRAIN;
                    else
                        addr <= addr + 1'b1;
                end
                ST_DRAIN: begin
                    if (!pending)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    pass_q <= (err_count == '0) && !aborted;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign pass = done ? ((err_count == '0) && !aborted) : pass_q;

    assign avm_chipselect = (state == ST_WRITE) || (state == ST_READ);
    assign avm_write      = (state == ST_WRITE);
    assign avm_address    = avm_chipselect ? addr : '0;
    assign avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
    assign avm_writedata  = avm_write ? pat : '0;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_nios2pio_memtest_master.sv
// Self-checking bench: two masters (read latency 1 and 2) on RAM models,
// bus accesses scored against an expected-access queue.
module tb_nios2pio_memtest_master;

    localparam int DEPTH = 2048;

    typedef struct packed {
        logic        wr;
        logic [10:0] a;
        logic [31:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = 32'd0;

    logic        busy1, done1, pass1, cs1, wr1, clken1;
    logic [11:0] err1;
    logic [10:0] fea1, a1;
    logic [31:0] fed1, wd1, rd1;
    logic [3:0]  be1;

    logic        busy2, done2, pass2, cs2, wr2, clken2;
    logic [11:0] err2;
    logic [10:0] fea2, a2;
    logic [31:0] fed2, wd2, rd2a, rd2b;
    logic [3:0]  be2;

    logic [31:0] mem1 [DEPTH];
    logic [31:0] mem2 [DEPTH];
    logic        zero_mem = 1'b0;
    logic        flip_en = 1'b0;
    logic [10:0] flip_addr = 11'd0;

    acc_t sb[$];
    acc_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nios2pio_memtest_master #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .start(start), .mode(mode),
        .seed(seed), .abort(abort), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_err_addr(fea1),
        .first_err_data(fed1), .avm_address(a1), .avm_chipselect(cs1),
        .avm_write(wr1), .avm_byteenable(be1), .avm_writedata(wd1),
        .avm_clken(clken1), .avm_readdata(rd1)
    );

    nios2pio_memtest_master #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(rst_n), .start(start), .mode(mode),
        .seed(seed), .abort(abort), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .first_err_addr(fea2),
        .first_err_data(fed2), .avm_address(a2), .avm_chipselect(cs2),
        .avm_write(wr2), .avm_byteenable(be2), .avm_writedata(wd2),
        .avm_clken(clken2), .avm_readdata(rd2b)
    );

    // RAM models: registered read, optional corruption / all-zero readback
    always @(posedge clk) begin
        if (cs1 && wr1) mem1[a1] <= wd1;
        if (cs2 && wr2) mem2[a2] <= wd2;
        rd1  <= zero_mem ? 32'd0 :
                mem1[a1] ^ {31'd0, flip_en && (a1 == flip_addr)};
        rd2a <= zero_mem ? 32'd0 :
                mem2[a2] ^ {31'd0, flip_en && (a2 == flip_addr)};
        rd2b <= rd2a;
    end

    function automatic logic [31:0] pat(input logic [31:0] s, input int a);
        int v;
        v = (a << 21) | (((~a) & 32'h7FF) << 10) | (a & 32'h3FF);
        return s ^ 32'(v);
    endfunction

    always @(negedge clk) begin
        if (rst_n && cs1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: wr=%0b addr=%0d, required no access",
                         wr1, a1);
            end else begin
                mon_e = sb.pop_front();
                if (wr1 !== mon_e.wr || a1 !== mon_e.a || be1 !== 4'hF ||
                    (mon_e.wr && wd1 !== mon_e.d)) begin
                    errors++;
                    $display("FAIL bus_access: got wr=%0b a=%0d be=%h d=%h, required wr=%0b a=%0d be=f d=%h",
                             wr1, a1, be1, wd1, mon_e.wr, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic launch(input logic [1:0] m, input logic [31:0] s);
        sb.delete();
        if (m != 2'd1)
            for (int i = 0; i < DEPTH; i++)
                sb.push_back({1'b1, 11'(i), pat(s, i)});
        if (m != 2'd0)
            for (int i = 0; i < DEPTH; i++)
                sb.push_back({1'b0, 11'(i), 32'd0});
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        seed  = s;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int c1, output int c2, output logic b1);
        c1 = -1;
        c2 = -1;
        b1 = 1'b0;
        for (int n = 1; n <= 5000 && (c1 < 0 || c2 < 0); n++) begin
            @(negedge clk);
            if (n == 1) b1 = busy1;
            if (done1 && c1 < 0) c1 = n;
            if (done2 && c2 < 0) c2 = n;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, pass1, cs1, wr1, clken1} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_ctrl1: got busy,done,pass,cs,wr,clken=%b, required 000001",
                     {busy1, done1, pass1, cs1, wr1, clken1});
        end
        checks++;
        if (err1 !== 12'd0 || fea1 !== 11'd0 || fed1 !== 32'd0 ||
            a1 !== 11'd0 || be1 !== 4'd0 || wd1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_data1: got err=%0d fea=%0d fed=%h a=%0d be=%h wd=%h, required all 0",
                     err1, fea1, fed1, a1, be1, wd1);
        end
        checks++;
        if ({busy2, done2, pass2, cs2, clken2} !== 5'b00001 || err2 !== 12'd0) begin
            errors++;
            $display("FAIL reset_dut2: got busy,done,pass,cs,clken=%b err=%0d, required 00001 err=0",
                     {busy2, done2, pass2, cs2, clken2}, err2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_check();
        int c1, c2;
        logic b1;
        launch(2'd2, 32'h0);
        wait_done(c1, c2, b1);
        checks++;
        if (b1 !== 1'b1) begin
            errors++;
            $display("FAIL fc_busy_rise: got %b, required 1", b1);
        end
        checks++;
        if (c1 != 4098) begin
            errors++;
            $display("FAIL fc_done_cycle_l1: got %0d, required 4098", c1);
        end
        checks++;
        if (pass1 !== 1'b1 || err1 !== 12'd0) begin
            errors++;
            $display("FAIL fc_result_l1: got pass=%b err=%0d, required pass=1 err=0",
                     pass1, err1);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL fc_busy_fall: got %b, required 0", busy1);
        end
        checks++;
        if (mem1[5] !== pat(32'h0, 5)) begin
            errors++;
            $display("FAIL fc_word5: got %h, required %h", mem1[5], pat(32'h0, 5));
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fc_all_accesses: got %0d left, required 0", sb.size());
        end
    endtask

    task automatic test_latency2();
        int c1, c2;
        logic b1;
        launch(2'd2, 32'hA5A5_5A5A);
        wait_done(c1, c2, b1);
        checks++;
        if (c2 != 4099) begin
            errors++;
            $display("FAIL l2_done_cycle: got %0d, required 4099", c2);
        end
        checks++;
        if (pass2 !== 1'b1 || err2 !== 12'd0) begin
            errors++;
            $display("FAIL l2_result: got pass=%b err=%0d, required pass=1 err=0",
                     pass2, err2);
        end
    endtask

    task automatic test_check_corrupt();
        int c1, c2;
        logic b1;
        flip_en   = 1'b1;
        flip_addr = 11'd100;
        launch(2'd1, 32'hA5A5_5A5A);
        wait_done(c1, c2, b1);
        checks++;
        if (c1 != 2050 || c2 != 2051) begin
            errors++;
            $display("FAIL chk_done_cycles: got %0d/%0d, required 2050/2051", c1, c2);
        end
        checks++;
        if (pass1 !== 1'b0 || err1 !== 12'd1 || fea1 !== 11'd100) begin
            errors++;
            $display("FAIL chk_result: got pass=%b err=%0d fea=%0d, required pass=0 err=1 fea=100",
                     pass1, err1, fea1);
        end
        checks++;
        if (fed1 !== (pat(32'hA5A5_5A5A, 100) ^ 32'd1)) begin
            errors++;
            $display("FAIL chk_first_data: got %h, required %h",
                     fed1, pat(32'hA5A5_5A5A, 100) ^ 32'd1);
        end
        checks++;
        if (err2 !== 12'd1 || fea2 !== 11'd100) begin
            errors++;
            $display("FAIL chk_result_l2: got err=%0d fea=%0d, required err=1 fea=100",
                     err2, fea2);
        end
        flip_en = 1'b0;
    endtask

    task automatic test_saturate();
        int c1, c2;
        logic b1;
        zero_mem = 1'b1;
        launch(2'd1, 32'hFFFF_FFFF);
        wait_done(c1, c2, b1);
        checks++;
        if (err1 !== 12'd2048 || fea1 !== 11'd0 || fed1 !== 32'd0 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL sat_result: got err=%0d fea=%0d fed=%h pass=%b, required 2048 0 0 0",
                     err1, fea1, fed1, pass1);
        end
        checks++;
        if (err2 !== 12'd2048) begin
            errors++;
            $display("FAIL sat_result_l2: got err=%0d, required 2048", err2);
        end
    endtask

    task automatic test_abort();
        int   nreads = 0;
        logic d1 = 1'b0;
        logic d2 = 1'b0;
        zero_mem = 1'b1;
        launch(2'd1, 32'h0);
        for (int n = 1; n <= 3000 && !(d1 && d2); n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) mode = 2'd0;
            if (cs1 && !wr1) nreads++;
            abort = cs1 && !wr1 && (a1 == 11'd10);
            if (done1) d1 = 1'b1;
            if (done2) d2 = 1'b1;
        end
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (nreads != 11 || d1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_reads: got reads=%0d done=%b, required 11 1", nreads, d1);
        end
        checks++;
        if (err1 !== 12'd11 || pass1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_compares: got err=%0d pass=%b, required 11 0", err1, pass1);
        end
        checks++;
        if (d2 !== 1'b1 || pass2 !== 1'b0) begin
            errors++;
            $display("FAIL abort_l2: got done=%b pass=%b, required 1 0", d2, pass2);
        end
        sb.delete();
        zero_mem = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int   c1, c2;
        logic b1;
        logic dn = 1'b0;
        launch(2'd0, 32'h1357_9BDF);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, pass1, cs1, wr1, clken1} !== 6'b000001 ||
            a1 !== 11'd0 || wd1 !== 32'd0 || be1 !== 4'd0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got ctrl=%b a=%0d wd=%h be=%h busy2=%b, required 000001 0 0 0 0",
                     {busy1, done1, pass1, cs1, wr1, clken1}, a1, wd1, be1, busy2);
        end
        sb.delete();
        repeat (5) begin
            @(negedge clk);
            if (done1 || done2) dn = 1'b1;
        end
        checks++;
        if (dn !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: got %b, required 0", dn);
        end
        rst_n = 1'b1;
        launch(2'd0, 32'h2468_ACE0);
        wait_done(c1, c2, b1);
        checks++;
        if (c1 != 2049 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL rst_rerun: got done=%0d pass=%b, required 2049 1", c1, pass1);
        end
        checks++;
        if (mem1[7] !== pat(32'h2468_ACE0, 7)) begin
            errors++;
            $display("FAIL rst_word7: got %h, required %h", mem1[7], pat(32'h2468_ACE0, 7));
        end
    endtask

    initial begin
        test_reset();
        test_fill_check();
        test_latency2();
        test_check_corrupt();
        test_saturate();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
